// File: rtl/fetch_decode_fsm.sv
// fetch_decode_fsm: owns PC, fetches over mem_rd/mem_ready into IR, decodes and dispatches one-hot start to MOVI/MOV/ADD/SUB op FSMs, handles JMP/HALT/illegal
module fetch_decode_fsm #(
  parameter int PC_W    = 8,
  parameter int IW      = 16,
  parameter int NUM_OPS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic [PC_W-1:0]    mem_addr,
  output logic               mem_rd,
  input  logic               mem_ready,
  input  logic [IW-1:0]      mem_data,
  output logic               donefetch,
  output logic [NUM_OPS-1:0] start,
  output logic [5:0]         parameter1,
  output logic [5:0]         parameter2,
  input  logic [NUM_OPS-1:0] done,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic               illegal
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;
  state_t state;
  logic [IW-1:0] ir;
  logic [3:0] opc;
  logic run_q;
  logic bad;
  assign opc = ir[15:12];
  assign mem_addr = pc;
  assign parameter1 = ir[11:6];
  assign parameter2 = ir[5:0];
  assign bad = !(mem_data[15:12] <= 4'h4 || mem_data[15:12] == 4'hf);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      ir <= '0;
      run_q <= 1'b0;
      mem_rd <= 1'b0;
      donefetch <= 1'b0;
      start <= '0;
      halted <= 1'b0;
      illegal <= 1'b0;
    end else begin
      run_q <= run;
      donefetch <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE:
          if (run) begin
            mem_rd <= 1'b1;
            state <= FETCH;
          end
        FETCH:
          if (mem_ready) begin
            ir <= mem_data;
            mem_rd <= 1'b0;
            donefetch <= 1'b1;
            illegal <= bad;
            state <= DECODE;
          end
        DECODE:
          if (opc < 4'h4) begin
            start <= NUM_OPS'(1) << opc[1:0];
            state <= EXEC;
          end else if (opc == 4'h4) begin
            pc <= ir[PC_W-1:0];
            mem_rd <= 1'b1;
            state <= FETCH;
          end else if (opc == 4'hf) begin
            halted <= 1'b1;
            state <= HALT;
          end else begin
            pc <= pc + PC_W'(1);
            mem_rd <= 1'b1;
            state <= FETCH;
          end
        EXEC:
          if (|(done & start)) begin
            start <= '0;
            pc <= pc + PC_W'(1);
            mem_rd <= 1'b1;
            state <= FETCH;
          end
        HALT:
          if (run && !run_q) begin
            halted <= 1'b0;
            pc <= pc + PC_W'(1);
            mem_rd <= 1'b1;
            state <= FETCH;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fetch_decode_fsm.sv
// tb_fetch_decode_fsm: directed and randomized instruction streams checked against a transaction-level program model
module tb_fetch_decode_fsm;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
  logic mem_ready = 1'b0;
  logic [15:0] mem_data = '0;
  logic [3:0] done = '0;
  logic [7:0] mem_addr, pc;
  logic mem_rd, donefetch, halted, illegal;
  logic [3:0] start;
  logic [5:0] parameter1, parameter2;
  logic [15:0] mem [256];
  logic [7:0] exp_pc;
  int compared = 0;
  int mismatched = 0;
  int df_cnt = 0;
  int fetches = 0;
  int last_lat = 0;
  always #5 clk = ~clk;
  fetch_decode_fsm dut (
    .clk(clk), .rst(rst), .run(run), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_ready(mem_ready), .mem_data(mem_data), .donefetch(donefetch), .start(start),
    .parameter1(parameter1), .parameter2(parameter2), .done(done), .pc(pc),
    .halted(halted), .illegal(illegal)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(posedge clk) if (donefetch === 1'b1) df_cnt++;
  always @(negedge clk)
    if (!rst) begin
      chk("onehot_start", 32'($countones(start) <= 1), 1);
      chk("start_with_rd", 32'((|start) && mem_rd), 0);
    end
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_rd"}, mem_rd, 0);
    chk({tag, "_df"}, donefetch, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_illegal"}, illegal, 0);
  endtask
  task automatic exec_one(input int w, input int d, input logic [3:0] stray, input bit abort);
    logic [15:0] ins;
    logic [3:0] op;
    logic [3:0] bit_op;
    int n;
    n = 0;
    while (mem_rd !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    last_lat = n;
    chk("fetch_rd", mem_rd, 1);
    chk("fetch_addr", mem_addr, exp_pc);
    repeat (w) begin
      @(negedge clk);
      chk("wait_rd", mem_rd, 1);
      chk("wait_addr", mem_addr, exp_pc);
      chk("wait_df", donefetch, 0);
    end
    ins = mem[exp_pc];
    op = ins[15:12];
    bit_op = 4'b0001 << op[1:0];
    mem_ready = 1'b1;
    mem_data = ins;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_data = 16'($urandom);
    fetches++;
    chk("donefetch", donefetch, 1);
    chk("decode_rd", mem_rd, 0);
    chk("decode_start", start, 0);
    chk("illegal", illegal, 32'(op >= 4'd5 && op <= 4'd14));
    @(negedge clk);
    chk("df_pulse", donefetch, 0);
    chk("illegal_pulse", illegal, 0);
    if (op < 4'd4) begin
      chk("start", start, bit_op);
      chk("param1", parameter1, ins[11:6]);
      chk("param2", parameter2, ins[5:0]);
      if (abort) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_start", start, 0);
        chk("rst_pc", pc, 0);
        chk("rst_rd", mem_rd, 0);
        exp_pc = '0;
        return;
      end
      repeat (d) begin
        done = stray & ~bit_op;
        @(negedge clk);
        chk("hold_start", start, bit_op);
        chk("hold_param1", parameter1, ins[11:6]);
        chk("hold_param2", parameter2, ins[5:0]);
        chk("exec_rd", mem_rd, 0);
      end
      done = bit_op | stray;
      @(negedge clk);
      done = '0;
      chk("start_drop", start, 0);
      exp_pc++;
    end else if (op == 4'd4) begin
      chk("jmp_start", start, 0);
      exp_pc = ins[7:0];
    end else if (op == 4'd15) begin
      chk("halted", halted, 1);
      repeat (10) begin
        @(negedge clk);
        chk("halt_no_rd", mem_rd, 0);
        chk("halt_hold", halted, 1);
      end
      run = 1'b0;
      @(negedge clk);
      chk("halt_run_low", mem_rd, 0);
      run = 1'b1;
      @(negedge clk);
      chk("resume_halted", halted, 0);
      exp_pc++;
    end else begin
      chk("illegal_start", start, 0);
      exp_pc++;
    end
    chk("next_rd", mem_rd, 1);
    chk("next_pc", pc, exp_pc);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [3:0] o;
    int r;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = 16'h0003;
    mem[1] = 16'h4005;
    mem[5] = 16'h7000;
    mem[6] = 16'hF000;
    mem[7] = 16'h2ABC;
    exp_pc = '0;
    #1 rst = 1'b1;
    #2;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("idle_no_run");
    run = 1'b1;
    exec_one(0, 2, 4'b0000, 0);
    chk("first_fetch_lat", last_lat, 1);
    exec_one(3, 0, 4'b0000, 0);
    chk("jmp_target", pc, 8'h05);
    exec_one(0, 0, 4'b0000, 0);
    exec_one(1, 0, 4'b0000, 0);
    exec_one(1, 0, 4'b0000, 1);
    run = 1'b0;
    @(negedge clk);
    chk_idle_outputs("in_reset");
    rst = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("stale_ready_rd", mem_rd, 0);
    chk("stale_ready_df", donefetch, 0);
    mem_ready = 1'b0;
    run = 1'b1;
    mem[1] = 16'h40FF;
    mem[8'hFF] = 16'h2041;
    exec_one(0, 1, 4'b0000, 0);
    exec_one(0, 0, 4'b0000, 0);
    chk("jmp_ff", pc, 8'hFF);
    exec_one(2, 2, 4'b0010, 0);
    chk("pc_wrap", pc, 8'h00);
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 19);
      o = r < 12 ? 4'(r % 4) : r < 15 ? 4'd4 : r < 19 ? 4'($urandom_range(5, 14)) : 4'd15;
      mem[i] = {o, 12'($urandom)};
    end
    for (int k = 0; k < 60; k++)
      exec_one($urandom_range(0, 3), $urandom_range(0, 3), 4'($urandom), 0);
    @(negedge clk);
    chk("donefetch_count", df_cnt, fetches);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
